// File: rtl/param_stream_dmux.sv
// Single-entry registered stream demultiplexer: routes each input beat to one of N output channels.
// Optional per-channel saturating transfer counters on f_cnt when PARAM_STREAM_DMUX_STATS_EN is defined.
module param_stream_dmux #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [W-1:0]    i_data,
  input  logic [SW-1:0]   i_sel,
  output logic            i_ready,
  output logic [N-1:0]    f_valid,
  output logic [N*W-1:0]  f_data,
  input  logic [N-1:0]    f_ready,
  output logic            o_err
`ifdef PARAM_STREAM_DMUX_STATS_EN
  ,
  output logic [N*16-1:0] f_cnt
`endif
);

  // state | meaning
  // EMPTY | no beat held; input always ready
  // FULL  | beat held in data_q for channel sel_q; ready follows f_ready[sel_q]
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SW:0] N_LIM = (SW+1)'(N);

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            err_q, err_d;
  logic [(1<<SW)-1:0] rdy_ext;
  logic            sel_legal, in_xfer, out_xfer;

  // Padded so every sel_q code indexes a real bit, even for non-power-of-two N.
  assign rdy_ext   = ((1 << SW))'(f_ready);
  assign sel_legal = ({1'b0, i_sel} < N_LIM);
  assign out_xfer  = (state_q == FULL) && rdy_ext[sel_q];
  assign i_ready   = (state_q == EMPTY) || rdy_ext[sel_q];
  assign in_xfer   = i_valid && i_ready;
  assign o_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = in_xfer && !sel_legal;
    case (state_q)
      EMPTY: begin
        if (in_xfer && sel_legal) begin
          state_d = FULL;
          data_d  = i_data;
          sel_d   = i_sel;
        end
      end
      FULL: begin
        // Input can only be accepted here when the held beat leaves this cycle.
        if (out_xfer) begin
          if (in_xfer && sel_legal) begin
            data_d = i_data;
            sel_d  = i_sel;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign f_valid[k]         = (state_q == FULL) && (sel_q == SW'(k));
    assign f_data[k*W +: W]   = f_valid[k] ? data_q : '0;

`ifdef PARAM_STREAM_DMUX_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (f_valid[k] && f_ready[k] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign f_cnt[k*16 +: 16] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_param_stream_dmux.sv
// Bench for param_stream_dmux: N=4 and N=5 instances, directed table, corner sequences,
// randomized traffic against a reference model, and counter checks when stats are enabled.
module tb_param_stream_dmux;

  logic clk;
  logic rst_n;

  logic       v4, ready4, err4;
  logic [1:0] sel4;
  logic [7:0] d4;
  logic [3:0] fr4, fv4;
  logic [31:0] fd4;

  logic       v5, ready5, err5;
  logic [2:0] sel5;
  logic [7:0] d5;
  logic [4:0] fr5, fv5;
  logic [39:0] fd5;

`ifdef PARAM_STREAM_DMUX_STATS_EN
  logic [63:0] cnt4;
  logic [79:0] cnt5;
`endif

  param_stream_dmux #(.N(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .i_valid(v4), .i_data(d4), .i_sel(sel4),
    .i_ready(ready4), .f_valid(fv4), .f_data(fd4), .f_ready(fr4), .o_err(err4)
`ifdef PARAM_STREAM_DMUX_STATS_EN
    , .f_cnt(cnt4)
`endif
  );

  param_stream_dmux #(.N(5), .W(8)) u5 (
    .clk(clk), .rst_n(rst_n), .i_valid(v5), .i_data(d5), .i_sel(sel5),
    .i_ready(ready5), .f_valid(fv5), .f_data(fd5), .f_ready(fr5), .o_err(err5)
`ifdef PARAM_STREAM_DMUX_STATS_EN
    , .f_cnt(cnt5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one optional held beat per DUT, plus a delivery scoreboard for the N=4 DUT.
  bit         mv[2];
  int         msel[2];
  logic [7:0] md[2];
  bit         merr[2];
  int         nch[2] = '{4, 5};

  typedef struct { int ch; logic [7:0] d; } beat_t;
  beat_t sb[$];

  function automatic bit m_ready(int k, logic [7:0] fr);
    return !mv[k] || fr[msel[k]];
  endfunction

  function automatic logic [7:0] e_fv(int k);
    return mv[k] ? 8'(1 << msel[k]) : 8'd0;
  endfunction

  function automatic logic [39:0] e_fd(int k);
    return mv[k] ? (40'(md[k]) << (8 * msel[k])) : 40'd0;
  endfunction

  task automatic m_update(input int k, input bit v, input int sel, input logic [7:0] d,
                          input logic [7:0] fr);
    bit acc, out;
    beat_t b;
    acc = v && m_ready(k, fr);
    out = mv[k] && fr[msel[k]];
    if (acc && sel < nch[k]) begin
      mv[k] = 1'b1; msel[k] = sel; md[k] = d;
      if (k == 0) begin b.ch = sel; b.d = d; sb.push_back(b); end
    end else if (out) begin
      mv[k] = 1'b0;
    end
    merr[k] = acc && (sel >= nch[k]);
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; msel[k] = 0; md[k] = 8'h00; merr[k] = 1'b0;
    end
    sb.delete();
  endtask

  // One clock cycle: inputs already driven; checks ready before the edge, state after it.
  task automatic step(input bit use_tbl, input bit t_rdy, input logic [3:0] t_fv,
                      input logic [31:0] t_fd, input bit t_err);
    logic [3:0] t;
    int ch;
    beat_t b;
    #1;
    chk("i_ready4", ready4, m_ready(0, 8'(fr4)));
    chk("i_ready5", ready5, m_ready(1, 8'(fr5)));
    if (use_tbl) chk("tbl_i_ready", ready4, t_rdy);
    t = fv4 & fr4;
    if (t != 4'b0) begin
      ch = 0;
      for (int i = 0; i < 4; i++) if (t[i]) ch = i;
      if (sb.size() == 0) begin
        chk("sb_spurious_xfer", t, 0);
      end else begin
        b = sb.pop_front();
        chk("sb_channel", ch, b.ch);
        chk("sb_data", fd4[ch*8 +: 8], b.d);
      end
    end
    @(posedge clk);
    m_update(0, v4, int'(sel4), d4, 8'(fr4));
    m_update(1, v5, int'(sel5), d5, 8'(fr5));
    #1;
    chk("f_valid4", fv4, e_fv(0));
    chk("f_data4", fd4, e_fd(0));
    chk("o_err4", err4, merr[0]);
    chk("f_valid5", fv5, e_fv(1));
    chk("f_data5", fd5, e_fd(1));
    chk("o_err5", err5, merr[1]);
    if (use_tbl) begin
      chk("tbl_f_valid", fv4, t_fv);
      chk("tbl_f_data", fd4, t_fd);
      chk("tbl_o_err", err4, t_err);
    end
  endtask

  task automatic idle_inputs();
    v4 = 1'b0; sel4 = 2'd0; d4 = 8'h00; fr4 = 4'b0;
    v5 = 1'b0; sel5 = 3'd0; d5 = 8'h00; fr5 = 5'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; logic [1:0] sel; logic [7:0] d; logic [3:0] fr;
    bit rdy; logic [3:0] fv; logic [31:0] fd; bit err;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 8'hFF, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 32'h0000_0010, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 32'h0000_1100, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0100, 32'h0012_0000, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b1000, 32'h1300_0000, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, 4'b1000, 32'h1300_0000, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 4'b0000, 32'h0000_0000, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 8'h3C, 4'b0000, 1'b1, 4'b0010, 32'h0000_3C00, 1'b0});
    tbl.push_back('{1'b1, 2'd0, 8'hAA, 4'b1101, 1'b0, 4'b0010, 32'h0000_3C00, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 8'hBB, 4'b1101, 1'b0, 4'b0010, 32'h0000_3C00, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 8'hCC, 4'b1101, 1'b0, 4'b0010, 32'h0000_3C00, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 8'hDD, 4'b0010, 1'b1, 4'b0100, 32'h00DD_0000, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 32'h0000_0000, 1'b0});

    idle_inputs();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_f_valid", fv4, 0);
    chk("rst_f_data", fd4, 0);
    chk("rst_o_err", err4, 0);
    chk("rst_i_ready", ready4, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_i_ready", ready4, 1);
    chk("post_rst_f_valid", fv4, 0);

    foreach (tbl[i]) begin
      v4 = tbl[i].v; sel4 = tbl[i].sel; d4 = tbl[i].d; fr4 = tbl[i].fr;
      step(1'b1, tbl[i].rdy, tbl[i].fv, tbl[i].fd, tbl[i].err);
    end

    // Reset asserted asynchronously while a beat is held; nothing may appear after release.
    idle_inputs();
    v4 = 1'b1; sel4 = 2'd1; d4 = 8'h5A;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("pre_rst_full", fv4, 4'b0010);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_f_valid", fv4, 0);
    chk("async_rst_f_data", fd4, 0);
    chk("async_rst_i_ready", ready4, 1);
    v4 = 1'b0; fr4 = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
      chk("no_delivery_after_rst", fv4, 0);
    end

    // N=5: illegal selects are dropped with a one-cycle o_err pulse.
    idle_inputs();
    v5 = 1'b1; sel5 = 3'd6; d5 = 8'h33;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("n5_err_pulse", err5, 1);
    chk("n5_err_no_valid", fv5, 0);
    v5 = 1'b0;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("n5_err_one_cycle", err5, 0);
    v5 = 1'b1; sel5 = 3'd4; d5 = 8'h44;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("n5_last_channel_valid", fv5, 5'b10000);
    chk("n5_last_channel_data", fd5, 40'h44_0000_0000);
    sel5 = 3'd5; d5 = 8'h55; fr5 = 5'b10000;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("n5_drop_with_xfer_valid", fv5, 0);
    chk("n5_drop_with_xfer_err", err5, 1);
    v5 = 1'b0; fr5 = 5'b0;
    step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    chk("n5_err_cleared", err5, 0);

    for (int i = 0; i < 3000; i++) begin
      v4   = ($urandom_range(0, 3) != 0);
      sel4 = 2'($urandom_range(0, 3));
      d4   = 8'($urandom);
      fr4  = 4'($urandom);
      v5   = ($urandom_range(0, 3) != 0);
      sel5 = 3'($urandom_range(0, 7));
      d5   = 8'($urandom);
      fr5  = 5'($urandom);
      step(1'b0, 1'b0, 4'b0, 32'h0, 1'b0);
    end

`ifdef PARAM_STREAM_DMUX_STATS_EN
    idle_inputs();
    do_reset();
    chk("cnt_after_reset", cnt4, 0);
    v4 = 1'b1; sel4 = 2'd0; d4 = 8'h01; fr4 = 4'b0001;
    repeat (11) @(posedge clk);
    #1;
    chk("cnt_ch0_10", cnt4[15:0], 16'd10);
    repeat (70000) @(posedge clk);
    #1;
    v4 = 1'b0;
    chk("cnt_ch0_saturated", cnt4[15:0], 16'hFFFF);
    chk("cnt_other_channels", cnt4[63:16], 0);
    @(posedge clk);
    #1;
    chk("cnt_ch0_holds", cnt4[15:0], 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
